// File: rtl/control_funcion_conf.sv
// Configuration-mode sequencer: turns debounced buttons into funcion_conf/campo codes.
// Optional inactivity auto-exit is enabled by defining TIMEOUT_CONF_EN.
module control_funcion_conf #(
    parameter logic [31:0] TIMEOUT_CICLOS = 32'd500_000_000,
    parameter int          ANCHO_CNT      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_modo,
    input  logic       btn_campo,
    input  logic       btn_salir,
    output logic [1:0] funcion_conf,
    output logic [1:0] campo,
    output logic       modo_activo,
    output logic       pulso_fin
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HORA  = 2'b01,
        FECHA = 2'b10,
        TIMER = 2'b11
    } estado_t;

    estado_t    state_reg, state_next;
    logic [1:0] campo_reg, campo_next;
    logic       pulso_reg, pulso_next;
    logic       activo_reg;

    // Bit 0 = modo, bit 1 = campo, bit 2 = salir
    logic [2:0] btn_vec;
    logic [2:0] prev_reg;
    logic [2:0] evento;

    assign btn_vec = {btn_salir, btn_campo, btn_modo};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flanco
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prev_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi] <= btn_vec[gi];
                end
            end
            assign evento[gi] = btn_vec[gi] & ~prev_reg[gi];
        end
    endgenerate

`ifdef TIMEOUT_CONF_EN
    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(TIMEOUT_CICLOS - 32'd1);

    logic [ANCHO_CNT-1:0] cnt_reg, cnt_next;
    logic                 aceptado;

    // salir and campo count as activity only where they actually do something
    assign aceptado = evento[0] | ((evento[1] | evento[2]) & (state_reg != IDLE));
`endif

    always_comb begin
        state_next = state_reg;
        campo_next = campo_reg;
        pulso_next = 1'b0;
        if (evento[2] && state_reg != IDLE) begin
            state_next = IDLE;
            campo_next = 2'd0;
            pulso_next = 1'b1;
        end else if (evento[0]) begin
            campo_next = 2'd0;
            case (state_reg)
                IDLE:    state_next = HORA;
                HORA:    state_next = FECHA;
                FECHA:   state_next = TIMER;
                default: begin
                    state_next = IDLE;
                    pulso_next = 1'b1;
                end
            endcase
        end else if (evento[1] && state_reg != IDLE) begin
            campo_next = (campo_reg == 2'd2) ? 2'd0 : campo_reg + 2'd1;
`ifdef TIMEOUT_CONF_EN
        end else if (state_reg != IDLE && cnt_reg == CNT_FIN) begin
            state_next = IDLE;
            campo_next = 2'd0;
            pulso_next = 1'b1;
`endif
        end
    end

`ifdef TIMEOUT_CONF_EN
    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (aceptado || state_next == IDLE) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            campo_reg  <= 2'd0;
            pulso_reg  <= 1'b0;
            activo_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            campo_reg  <= campo_next;
            pulso_reg  <= pulso_next;
            activo_reg <= (state_next != IDLE);
        end
    end

    assign funcion_conf = state_reg;
    assign campo        = campo_reg;
    assign modo_activo  = activo_reg;
    assign pulso_fin    = pulso_reg;

endmodule

// File: tb/tb_control_funcion_conf.sv
// Self-checking bench for control_funcion_conf: vector table, corner sequences, random vs model.
module tb_control_funcion_conf;

`ifdef TIMEOUT_CONF_EN
    localparam int TO         = 10;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TO         = 500_000_000;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_modo, btn_campo, btn_salir;
    logic [1:0] funcion_conf, campo;
    logic       modo_activo, pulso_fin;

    control_funcion_conf #(
        .TIMEOUT_CICLOS(32'(TO)),
        .ANCHO_CNT     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_modo    (btn_modo),
        .btn_campo   (btn_campo),
        .btn_salir   (btn_salir),
        .funcion_conf(funcion_conf),
        .campo       (campo),
        .modo_activo (modo_activo),
        .pulso_fin   (pulso_fin)
    );

    always #5 clk = ~clk;

    wire [5:0] outs = {funcion_conf, campo, modo_activo, pulso_fin};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode number, field number, last pulse, quiet cycles
    int m_mode, m_campo, m_quiet;
    bit m_pulse, pm, pc, ps;

    task automatic model_reset();
        m_mode = 0; m_campo = 0; m_quiet = 0; m_pulse = 0;
        pm = 0; pc = 0; ps = 0;
    endtask

    task automatic model_step(input logic m, input logic c, input logic s);
        bit em, ec, es;
        em = m && !pm; ec = c && !pc; es = s && !ps;
        pm = m; pc = c; ps = s;
        m_pulse = 0;
        if (es && m_mode != 0) begin
            m_mode = 0; m_campo = 0; m_pulse = 1; m_quiet = 0;
        end else if (em) begin
            m_pulse = (m_mode == 3);
            m_mode  = (m_mode + 1) % 4;
            m_campo = 0; m_quiet = 0;
        end else if (ec && m_mode != 0) begin
            m_campo = (m_campo + 1) % 3; m_quiet = 0;
        end else if (m_mode != 0) begin
            m_quiet++;
            if (TIMEOUT_ON && m_quiet == TO) begin
                m_mode = 0; m_campo = 0; m_pulse = 1; m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
    endtask

    function automatic logic [5:0] m_exp();
        return {2'(m_mode), 2'(m_campo), (m_mode != 0), m_pulse};
    endfunction

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got fc/campo/act/pulso=%b required %b", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic m, input logic c, input logic s);
        btn_modo = m; btn_campo = c; btn_salir = s;
        @(posedge clk);
        model_step(m, c, s);
        @(negedge clk);
    endtask

    typedef struct {
        logic       m, c, s;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[35];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        // {modo, campo, salir, {fc, campo, modo_activo, pulso_fin}}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b010010};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b010010};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'b010010};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'b010110};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b010110};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 6'b011010};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b011010};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'b010010};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'b010010};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 6'b010110};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 6'b100010};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 6'b100010};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 6'b100110};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 6'b100110};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 6'b101010};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 6'b101010};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 6'b000001};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 6'b000000};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 6'b000000};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 6'b010010};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 6'b010010};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 6'b100010};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 6'b100010};
        tbl[26] = '{1'b1, 1'b0, 1'b0, 6'b110010};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 6'b110010};
        tbl[28] = '{1'b1, 1'b0, 1'b0, 6'b000001};
        tbl[29] = '{1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[31] = '{1'b1, 1'b1, 1'b0, 6'b010010};
        tbl[32] = '{1'b0, 1'b0, 1'b0, 6'b010010};
        tbl[33] = '{1'b0, 1'b0, 1'b1, 6'b000001};
        tbl[34] = '{1'b0, 1'b0, 1'b0, 6'b000000};

        reset = 1'b1; btn_modo = 0; btn_campo = 0; btn_salir = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", outs, 6'b000000);
        reset = 1'b0;

        for (int i = 0; i < 35; i++) begin
            cyc(tbl[i].m, tbl[i].c, tbl[i].s);
            chk($sformatf("table[%0d]", i), outs, tbl[i].exp);
            $display("vec table[%0d] m=%b c=%b s=%b -> %b", i, tbl[i].m, tbl[i].c, tbl[i].s, outs);
        end

        // Held btn_modo must advance exactly once
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk($sformatf("held_modo[%0d]", i), outs, m_exp());
        end
        $display("seq held_modo done -> %b", outs);
        cyc(1'b0, 1'b0, 1'b0); chk("held_release", outs, m_exp());
        cyc(1'b0, 1'b0, 1'b1); chk("salir_after_held", outs, m_exp());
        cyc(1'b0, 1'b0, 1'b0); chk("salir_release", outs, m_exp());

        // Reach TIMER with campo=1, then reset asynchronously mid-cycle
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("pre_reset_timer", outs, 6'b110110);
        #2 reset = 1'b1;
        #1 chk("async_reset_now", outs, 6'b000000);
        $display("seq async_reset -> %b", outs);
        @(posedge clk); @(negedge clk); chk("reset_hold1", outs, 6'b000000);
        @(posedge clk); @(negedge clk); chk("reset_hold2", outs, 6'b000000);
        btn_campo = 0;
        reset = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0); chk("post_reset_no_pulse", outs, 6'b000000);

`ifdef TIMEOUT_CONF_EN
        begin
            int seen;
            for (int i = 0; i < 3; i++) begin
                cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
            end
            seen = -1;
            for (int n = 2; n <= 30 && seen < 0; n++) begin
                cyc(1'b0, 1'b0, 1'b0);
                if (pulso_fin) seen = n;
            end
            n_vec++;
            if (seen != 10) begin
                n_err++;
                $display("FAIL timeout_delay: got %0d cycles required 10", seen);
            end
            chk("timeout_idle", outs, 6'b000001);
            $display("seq timeout exit after %0d cycles", seen);

            cyc(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
            seen = -1;
            for (int n = 1; n <= 30 && seen < 0; n++) begin
                cyc(1'b0, 1'b0, 1'b0);
                if (pulso_fin) seen = n;
            end
            n_vec++;
            if (seen != 10) begin
                n_err++;
                $display("FAIL timeout_restart: got %0d cycles required 10", seen);
            end
            $display("seq timeout restart exit after %0d cycles", seen);
            cyc(1'b0, 1'b0, 1'b0); chk("timeout_pulse_once", outs, 6'b000000);
        end
`endif

        for (int i = 0; i < 500; i++) begin
            logic m, c, s;
            m = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 7) == 0);
            cyc(m, c, s);
            chk($sformatf("random[%0d]", i), outs, m_exp());
            $display("vec random[%0d] m=%b c=%b s=%b -> %b", i, m, c, s, outs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
